// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file writeback path.
// Used by regfile_wb_arbiter (optional RF_BYPASS_EN bypass ports) and wb_hold_slot.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding slot: valid/ready intake, frees on grant,
// silently drops requests targeting x0.
module wb_hold_slot
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              grant_i,
  output logic              ready_o,
  output logic              load_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign ready_o = !full_q || grant_i;
  // An x0 request completes its handshake but never occupies the slot.
  assign load_o  = valid_i && ready_o && (addr_i != ADDR_W'(REG_ZERO));

  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (grant_i) full_d = 1'b0;
    if (load_o) begin
      full_d = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register file write port between ALU and LSU slots, oldest first.
// Define RF_BYPASS_EN to add combinational bypass lookup ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
`ifdef RF_BYPASS_EN
  input  logic [ADDR_W-1:0] byp_addr1,
  input  logic [ADDR_W-1:0] byp_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2,
`endif
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              busy
);

  logic              alu_full, lsu_full, alu_load, lsu_load;
  logic              alu_grant, lsu_grant;
  logic [ADDR_W-1:0] alu_saddr, lsu_saddr;
  logic [DATA_W-1:0] alu_sdata, lsu_sdata;

  // age_q = 1 : ALU slot holds the older request; 0 : LSU older (also the tie case).
  logic              age_q, age_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .clk     (clk),
    .rst     (rst),
    .valid_i (alu_valid),
    .addr_i  (alu_addr),
    .data_i  (alu_data),
    .grant_i (alu_grant),
    .ready_o (alu_ready),
    .load_o  (alu_load),
    .full_o  (alu_full),
    .addr_o  (alu_saddr),
    .data_o  (alu_sdata)
  );

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lsu_slot (
    .clk     (clk),
    .rst     (rst),
    .valid_i (lsu_valid),
    .addr_i  (lsu_addr),
    .data_i  (lsu_data),
    .grant_i (lsu_grant),
    .ready_o (lsu_ready),
    .load_o  (lsu_load),
    .full_o  (lsu_full),
    .addr_o  (lsu_saddr),
    .data_o  (lsu_sdata)
  );

  assign alu_grant = alu_full && (!lsu_full || age_q);
  assign lsu_grant = lsu_full && (!alu_full || !age_q);

  always_comb begin
    age_d = age_q;
    if (alu_load && lsu_load)                    age_d = 1'b0;
    else if (alu_load && lsu_full && !lsu_grant) age_d = 1'b0;
    else if (lsu_load && alu_full && !alu_grant) age_d = 1'b1;

    we_d    = alu_grant || lsu_grant;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (lsu_grant) begin
      waddr_d = lsu_saddr;
      wdata_d = lsu_sdata;
    end else if (alu_grant) begin
      waddr_d = alu_saddr;
      wdata_d = alu_sdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      age_q   <= age_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = waddr_q;
  assign rf_data_in      = wdata_q;
  assign busy            = alu_full || lsu_full || we_q;

`ifdef RF_BYPASS_EN
  logic lsu_young;
  assign lsu_young = age_q || !alu_full;

  function automatic logic [DATA_W:0] byp_lookup(
    input logic [ADDR_W-1:0] a,
    input logic              yf, input logic [ADDR_W-1:0] ya, input logic [DATA_W-1:0] yd,
    input logic              of, input logic [ADDR_W-1:0] oa, input logic [DATA_W-1:0] od,
    input logic              wf, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd
  );
    logic [DATA_W:0] r;
    r = '0;
    if (a != ADDR_W'(REG_ZERO)) begin
      if (yf && ya == a)      r = {1'b1, yd};
      else if (of && oa == a) r = {1'b1, od};
      else if (wf && wa == a) r = {1'b1, wd};
    end
    return r;
  endfunction

  logic              yng_f, old_f;
  logic [ADDR_W-1:0] yng_a, old_a;
  logic [DATA_W-1:0] yng_d, old_d;

  always_comb begin
    yng_f = lsu_young ? lsu_full  : alu_full;
    yng_a = lsu_young ? lsu_saddr : alu_saddr;
    yng_d = lsu_young ? lsu_sdata : alu_sdata;
    old_f = lsu_young ? alu_full  : lsu_full;
    old_a = lsu_young ? alu_saddr : lsu_saddr;
    old_d = lsu_young ? alu_sdata : lsu_sdata;
    {byp_hit1, byp_data1} = byp_lookup(byp_addr1, yng_f, yng_a, yng_d,
                                       old_f, old_a, old_d, we_q, waddr_q, wdata_q);
    {byp_hit2, byp_data2} = byp_lookup(byp_addr2, yng_f, yng_a, yng_d,
                                       old_f, old_a, old_d, we_q, waddr_q, wdata_q);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; bypass checks compiled in with RF_BYPASS_EN.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, lsu_valid;
  logic              alu_ready, lsu_ready;
  logic [ADDR_W-1:0] alu_addr, lsu_addr;
  logic [DATA_W-1:0] alu_data, lsu_data;
  logic              rf_write_enable, busy;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_data_in;
`ifdef RF_BYPASS_EN
  logic [ADDR_W-1:0] byp_addr1 = '0, byp_addr2 = '0;
  logic              byp_hit1, byp_hit2;
  logic [DATA_W-1:0] byp_data1, byp_data2;
`endif

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .lsu_valid       (lsu_valid),
    .lsu_ready       (lsu_ready),
    .lsu_addr        (lsu_addr),
    .lsu_data        (lsu_data),
`ifdef RF_BYPASS_EN
    .byp_addr1       (byp_addr1),
    .byp_addr2       (byp_addr2),
    .byp_hit1        (byp_hit1),
    .byp_hit2        (byp_hit2),
    .byp_data1       (byp_data1),
    .byp_data2       (byp_data2),
`endif
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_data_in      (rf_data_in),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_writes = 0;
  int unsigned n_sat    = 0;
  logic        sat_mode = 1'b0;
  logic        prev_src;
  logic        acc_a, acc_l;
  wb_req_t     exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake sampled mid-cycle; accepted non-x0 requests enter the queue in
  // write order (LSU ahead of ALU when both land on the same edge).
  task automatic step();
    @(negedge clk);
    acc_a = alu_valid && alu_ready;
    acc_l = lsu_valid && lsu_ready;
    @(posedge clk);
    if (acc_l && lsu_addr != '0) exp_q.push_back('{addr: lsu_addr, data: lsu_data});
    if (acc_a && alu_addr != '0) exp_q.push_back('{addr: alu_addr, data: alu_data});
    #1;
  endtask

  always @(negedge clk) begin
    if (rf_write_enable) begin
      wb_req_t e;
      logic    src;
      n_writes++;
      if (exp_q.size() == 0) check_eq("unexpected_write", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 64'(rf_write_addr), 64'(e.addr));
        check_eq("wr_data", 64'(rf_data_in), 64'(e.data));
      end
      if (sat_mode) begin
        src = rf_write_addr[4];
        if (n_sat > 0) check_eq("sat_alternate", 64'(src), 64'(!prev_src));
        prev_src = src;
        n_sat++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned ia, il, base;
    rst = 1'b1;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_addr = '0; alu_data = '0; lsu_addr = '0; lsu_data = '0;
    repeat (2) step();
    check_eq("rst_we", 64'(rf_write_enable), 64'd0);
    check_eq("rst_addr", 64'(rf_write_addr), 64'd0);
    check_eq("rst_data", 64'(rf_data_in), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_alu_ready", 64'(alu_ready), 64'd1);
    check_eq("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    rst = 1'b0;
    step();

    // Reset mid-flight
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
    step();
    alu_valid = 1'b0;
    check_eq("t1_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_eq("t1_busy_async", 64'(busy), 64'd0);
    repeat (2) step();
    check_eq("t1_we", 64'(rf_write_enable), 64'd0);
    check_eq("t1_addr", 64'(rf_write_addr), 64'd0);
    check_eq("t1_data", 64'(rf_data_in), 64'd0);
    rst = 1'b0;
    repeat (3) step();
    check_eq("t1_busy_after", 64'(busy), 64'd0);

    // Single ALU write, latency and one-cycle pulse
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    check_eq("t2_we_edge0", 64'(rf_write_enable), 64'd0);
    step();
    check_eq("t2_we_edge1", 64'(rf_write_enable), 64'd1);
    check_eq("t2_addr", 64'(rf_write_addr), 64'd5);
    check_eq("t2_data", 64'(rf_data_in), 64'hDEADBEEF);
    step();
    check_eq("t2_we_edge2", 64'(rf_write_enable), 64'd0);
    check_eq("t2_addr_hold", 64'(rf_write_addr), 64'd5);

    // Simultaneous accept: LSU first
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'hB;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check_eq("t3_alu_ready", 64'(alu_ready), 64'd0);
    check_eq("t3_lsu_ready", 64'(lsu_ready), 64'd1);
    step();
    check_eq("t3_first_addr", 64'(rf_write_addr), 64'd2);
    check_eq("t3_alu_ready_next", 64'(alu_ready), 64'd1);
    step();
    check_eq("t3_second_addr", 64'(rf_write_addr), 64'd1);
    step();

    // Same address, LSU older
    lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h1;
    step();
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h2;
    step();
    alu_valid = 1'b0;
    check_eq("t4_first_data", 64'(rf_data_in), 64'h1);
    step();
    check_eq("t4_final_data", 64'(rf_data_in), 64'h2);
    repeat (2) step();

    // x0 drop
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hFFFF;
    #1;
    check_eq("t5_lsu_ready", 64'(lsu_ready), 64'd1);
    step();
    lsu_valid = 1'b0;
    check_eq("t5_busy", 64'(busy), 64'd0);
    step();
    check_eq("t5_we", 64'(rf_write_enable), 64'd0);
    check_eq("t5_busy2", 64'(busy), 64'd0);

    // Saturation: both streams continuous, 4 requests each
    ia = 0; il = 0;
    alu_valid = 1'b1; alu_addr = 5'd8;  alu_data = 32'hA000_0000;
    lsu_valid = 1'b1; lsu_addr = 5'd16; lsu_data = 32'hB000_0000;
    sat_mode = 1'b1; n_sat = 0; base = n_writes;
    for (int c = 0; c < 40 && (n_writes - base) < 8; c++) begin
      step();
      if (acc_a) begin
        ia++;
        if (ia == 4) alu_valid = 1'b0;
        else begin alu_addr = 5'(8 + ia); alu_data = 32'hA000_0000 + ia; end
      end
      if (acc_l) begin
        il++;
        if (il == 4) lsu_valid = 1'b0;
        else begin lsu_addr = 5'(16 + il); lsu_data = 32'hB000_0000 + il; end
      end
    end
    repeat (3) step();
    sat_mode = 1'b0;
    check_eq("t6_writes", 64'(n_writes - base), 64'd8);
    check_eq("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);

`ifdef RF_BYPASS_EN
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h77;
    lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h55;
    byp_addr1 = 5'd9; byp_addr2 = 5'd0;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check_eq("byp_hit_slots", 64'(byp_hit1), 64'd1);
    check_eq("byp_young", 64'(byp_data1), 64'h77);
    check_eq("byp_x0_hit", 64'(byp_hit2), 64'd0);
    check_eq("byp_x0_data", 64'(byp_data2), 64'd0);
    step();
    check_eq("byp_slot_over_out", 64'(byp_data1), 64'h77);
    step();
    check_eq("byp_out_hit", 64'(byp_hit1), 64'd1);
    check_eq("byp_out_data", 64'(byp_data1), 64'h77);
    step();
    check_eq("byp_miss_hit", 64'(byp_hit1), 64'd0);
    check_eq("byp_miss_data", 64'(byp_data1), 64'd0);
    byp_addr1 = '0;
`endif

    repeat (2) step();
    check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: ALU and load/store unit (LSU). Each requester has a one-entry holding slot with a valid/ready handshake. The oldest held request drives a registered write to the register file; writes to x0 are discarded. Sits between the execute/memory stages and the register file write port.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request valid
alu_ready  out  1  ALU slot can accept this cycle
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
lsu_valid  in  1  LSU writeback request valid
lsu_ready  out  1  LSU slot can accept this cycle
lsu_addr  in  ADDR_W  LSU destination register
lsu_data  in  DATA_W  load data
rf_write_enable  out  1  register file write enable (registered)
rf_write_addr  out  ADDR_W  register file write address (registered)
rf_data_in  out  DATA_W  register file write data (registered)
busy  out  1  any slot or output stage holds a pending write

Behaviour:
- Reset (async, immediate): both slots empty, age flag = 0, rf_write_enable=0, rf_write_addr=0, rf_data_in=0, busy=0. Reset mid-operation drops all pending writes; nothing is written afterwards.
- Accept: a transfer occurs when valid && ready at a rising clk edge; the slot captures addr/data.
- ready = slot empty OR slot granted this cycle (combinational; one request per requester per cycle at full throughput).
- Accept with addr==0: handshake completes and the request is dropped; the slot stays empty and no write is issued.
- Arbitration, each cycle: if exactly one slot is full, grant it. If both are full, grant the older one (age flag records which was accepted first). If both were accepted on the same edge, grant LSU first.
- Grant in cycle N: at edge N+1, rf_write_enable=1 with the slot's addr/data and the slot is freed. With no grant, rf_write_enable=0 and addr/data hold their previous values.
- Latency: request accepted at edge N gives rf_write_enable high in the cycle after edge N+1 at the earliest.
- Throughput: one register file write per cycle. With both streams continuous, grants alternate; the non-granted requester sees ready=0.
- Same-address pending in both slots: the older is written first, so the final register value is the younger request's data.
- busy = alu slot full | lsu slot full | rf_write_enable.
- No starvation: a slot waits at most one cycle for a grant.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: adds ports byp_addr1/byp_addr2 (in, ADDR_W) and byp_hit1/byp_hit2 (out, 1) plus byp_data1/byp_data2 (out, DATA_W), all combinational.
- A hit occurs when byp_addr matches a full slot or the active output stage (rf_write_enable=1).
- Priority on a hit: younger slot, then older slot, then output stage.
- byp_addr==0 never hits. On a miss, data = 0.
- Not defined: the ports are absent and behaviour is otherwise identical.

Decomposition:
- Shared package regfile_pkg holds: DATA_W/ADDR_W constants, the wb_req_t struct (addr, data), and the REG_ZERO constant (0).
- One sub-module, wb_hold_slot: a one-entry buffer with valid/ready, clear-on-grant, and x0 drop. It is instantiated twice (ALU, LSU).

Test Plan:
1. Reset mid-flight: ALU write r3=0x11 accepted, rst asserted next cycle -> no rf_write_enable ever; busy=0; outputs 0.
2. Single ALU write r5=0xDEADBEEF accepted at edge 0 -> rf_write_enable=1, addr=5, data=0xDEADBEEF after edge 1 for exactly one cycle.
3. Simultaneous accept ALU r1=0xA, LSU r2=0xB -> LSU write (r2=0xB) first cycle, ALU write (r1=0xA) next; alu_ready=0 for one cycle.
4. Same address: LSU r7=0x1 accepted, ALU r7=0x2 accepted one cycle later while LSU pending -> writes in order 0x1 then 0x2.
5. x0 drop: LSU addr=0 data=0xFFFF valid -> lsu_ready=1, no rf_write_enable, busy stays 0.
6. Saturation: both valid continuously for 8 cycles with distinct addresses -> 8 writes, strictly alternating, none lost or duplicated; with RF_BYPASS_EN, byp_addr1 equal to a pending addr returns hit=1 and the youngest data.
